crop_window_ctrl: RTL
=====================

Name: crop_window_ctrl

Overview:
- Runtime-configurable region-of-interest controller for the 416x416 AXI4-Stream video path.
- Tracks row and column position of every accepted beat and forwards only beats inside the active crop window.
- Regenerates tuser (SOF) and tlast (EOL) for the cropped stream.
- Shadows new window settings and applies them only at frame boundaries, so downstream lane-detection stages never see a torn frame.

Parameters:
- IMG_WIDTH, 416, pixels per input line
- IMG_HEIGHT, 416, lines per input frame
- DATA_W, 24, pixel bus width
- DEF_ROW_START, 0, reset value of active/shadow row start
- DEF_ROW_COUNT, 416, reset value of active/shadow row count
- DEF_COL_START, 0, reset value of active/shadow column start
- DEF_COL_COUNT, 416, reset value of active/shadow column count

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_video_tdata  in  DATA_W  input pixel
- s_axi_video_tvalid  in  1  input beat valid
- s_axi_video_tuser  in  1  input start of frame
- s_axi_video_tlast  in  1  input end of line
- s_axi_video_tready  out  1  input ready
- m_axi_video_tdata  out  DATA_W  cropped pixel
- m_axi_video_tvalid  out  1  cropped beat valid
- m_axi_video_tuser  out  1  cropped start of frame
- m_axi_video_tlast  out  1  cropped end of line
- m_axi_video_tready  in  1  downstream ready
- cfg_wr  in  1  one-cycle strobe; latch cfg_* into shadow
- cfg_row_start  in  clog2(IMG_HEIGHT)+1  first kept row
- cfg_row_count  in  clog2(IMG_HEIGHT)+1  kept rows
- cfg_col_start  in  clog2(IMG_WIDTH)+1  first kept column
- cfg_col_count  in  clog2(IMG_WIDTH)+1  kept columns
- cfg_err  out  1  pulse: rejected cfg_wr
- err_line  out  1  pulse: line length mismatch
- err_sof  out  1  pulse: SOF arrived mid-frame
- frame_done  out  1  pulse: last input beat of a frame accepted

Behaviour:
- Clocking/reset: clk, rst_n; asynchronous, active-low.
- Reset values:
  - State = WAIT_SOF; row/col counters = 0.
  - Active and shadow registers = DEF_*.
  - All pulse outputs = 0.
- Beat acceptance: a beat is accepted when s_tvalid && s_tready.
- Datapath latency: zero. m_tdata = s_tdata combinationally.
- Window test: in_win = state ACTIVE (or SOF beat in WAIT_SOF) && row in [row_start, row_start+row_count) && col in [col_start, col_start+col_count).
  - in_win: m_tvalid = s_tvalid and s_tready = m_tready.
  - Otherwise: m_tvalid = 0 and s_tready = 1. Out-of-window beats are dropped at full rate and never stall.
- m_tuser = in_win && row==row_start && col==col_start.
- m_tlast = in_win && col==col_start+col_count-1.
- FSM WAIT_SOF:
  - Accepted beats with tuser=0 are dropped; counters stay at 0.
  - An accepted beat with tuser=1 loads active <= shadow in the same cycle (window applies to that beat). That beat is row 0, col 0; col -> 1; state -> ACTIVE.
- FSM ACTIVE, per accepted beat:
  - col++.
  - If tlast, or col==IMG_WIDTH-1: col -> 0, row++.
  - err_line pulses if tlast and col != IMG_WIDTH-1, or col==IMG_WIDTH-1 without tlast.
  - End of frame: line end with row==IMG_HEIGHT-1 -> frame_done pulse, row -> 0, state -> WAIT_SOF.
- Mid-frame SOF: an accepted tuser=1 beat in ACTIVE pulses err_sof. Active <= shadow; the beat is treated as row 0, col 0 of a new frame; state stays ACTIVE.
- Config validation: cfg_wr accepted only if count != 0, start+count <= IMG_HEIGHT (rows) and start+count <= IMG_WIDTH (cols).
  - Valid: shadow updated next cycle.
  - Invalid: cfg_err pulses one cycle; shadow unchanged.
  - cfg_wr coincident with a SOF load: the SOF load uses the old shadow; the new value applies next frame.
- Arithmetic: window-end compares computed at counter width +1; no wrap possible after validation.
- Timing: pulse outputs are registered, asserted one cycle after the causing beat.
- Reset mid-frame: immediately returns to WAIT_SOF with DEF_* settings; m_tvalid drops to 0 combinationally.

Decomposition:
- Shared package video_pkg holds:
  - IMG_WIDTH/IMG_HEIGHT constants.
  - Row and column counter width constants.
  - The state enum (WAIT_SOF, ACTIVE).
- One natural sub-module: crop_pos_counter (row/col counters, line/frame-end detection, err_line/err_sof/frame_done). The top holds shadow/active config, the window compare and the handshake muxing.

Test Plan:
- Defaults, 416x416 frame, m_tready=1: all 173056 beats forwarded; m_tuser on beat 0; 416 m_tlast; one frame_done.
- cfg row_start=208, row_count=208, col_start=100, col_count=200 mid-frame:
  - Current frame unchanged.
  - Next frame outputs 208 lines of 200 beats; first m_tuser at input row 208, col 100; tlast at col 299.
- Random m_tready backpressure with the window above: s_tready low only on in-window beats when m_tready=0; output beat sequence identical to the no-backpressure run.
- Invalid cfg_wr (row_start=300, row_count=200, or col_count=0): cfg_err one cycle; subsequent frame uses the previous window.
- Error injection:
  - tlast at col 410: err_line pulses and the row advances.
  - tuser at row 50: err_sof pulses and row/col restart at 0.
  - Beats before the first SOF after reset are dropped.
- rst_n asserted at row 100: outputs return to reset values immediately; the next frame is cropped with DEF_* settings.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and FSM state type for the 416x416 video path.
package video_pkg;

   localparam int IMG_WIDTH  = 416;
   localparam int IMG_HEIGHT = 416;
   localparam int ROW_W      = $clog2(IMG_HEIGHT) + 1;
   localparam int COL_W      = $clog2(IMG_WIDTH) + 1;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } crop_state_e;

endpackage

// File: rtl/crop_pos_counter.sv
// Row/column position tracker for accepted beats with line/frame-end detection
// and registered err_line / err_sof / frame_done pulses.
module crop_pos_counter #(
   parameter int IMG_WIDTH  = video_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = video_pkg::IMG_HEIGHT,
   parameter int ROW_W      = $clog2(IMG_HEIGHT) + 1,
   parameter int COL_W      = $clog2(IMG_WIDTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     accept,
   input  logic                     sof,
   input  logic                     eol,
   output video_pkg::crop_state_e   state,
   output logic [ROW_W-1:0]         row,
   output logic [COL_W-1:0]         col,
   output logic                     err_line,
   output logic                     err_sof,
   output logic                     frame_done
);

   video_pkg::crop_state_e state_nxt;
   logic [ROW_W-1:0] row_nxt;
   logic [COL_W-1:0] col_nxt;
   logic err_line_nxt, err_sof_nxt, frame_done_nxt;
   logic at_w_end, at_h_end, line_end, active_beat;

   assign at_w_end    = (col == COL_W'(IMG_WIDTH - 1));
   assign at_h_end    = (row == ROW_W'(IMG_HEIGHT - 1));
   assign line_end    = eol || at_w_end;
   assign active_beat = accept && !sof && (state == video_pkg::ACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= video_pkg::WAIT_SOF;
         row        <= '0;
         col        <= '0;
         err_line   <= 1'b0;
         err_sof    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         row        <= row_nxt;
         col        <= col_nxt;
         err_line   <= err_line_nxt;
         err_sof    <= err_sof_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // A SOF beat always restarts the frame at (0,0), so the next beat is col 1.
   always_comb begin
      state_nxt = state;
      row_nxt   = row;
      col_nxt   = col;
      if (accept && sof) begin
         state_nxt = video_pkg::ACTIVE;
         row_nxt   = '0;
         col_nxt   = COL_W'(1);
      end else if (active_beat) begin
         if (line_end) begin
            col_nxt = '0;
            if (at_h_end) begin
               row_nxt   = '0;
               state_nxt = video_pkg::WAIT_SOF;
            end else begin
               row_nxt = row + ROW_W'(1);
            end
         end else begin
            col_nxt = col + COL_W'(1);
         end
      end
   end

   always_comb begin
      err_sof_nxt    = accept && sof && (state == video_pkg::ACTIVE);
      err_line_nxt   = active_beat && (eol != at_w_end);
      frame_done_nxt = active_beat && line_end && at_h_end;
   end

endmodule

// File: rtl/crop_window_ctrl.sv
// AXI4-Stream region-of-interest crop with frame-boundary shadowed window
// configuration and regenerated SOF/EOL sidebands.
module crop_window_ctrl #(
   parameter int IMG_WIDTH     = video_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT    = video_pkg::IMG_HEIGHT,
   parameter int DATA_W        = 24,
   parameter int DEF_ROW_START = 0,
   parameter int DEF_ROW_COUNT = 416,
   parameter int DEF_COL_START = 0,
   parameter int DEF_COL_COUNT = 416,
   localparam int ROW_W        = $clog2(IMG_HEIGHT) + 1,
   localparam int COL_W        = $clog2(IMG_WIDTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_axi_video_tdata,
   input  logic              s_axi_video_tvalid,
   input  logic              s_axi_video_tuser,
   input  logic              s_axi_video_tlast,
   output logic              s_axi_video_tready,
   output logic [DATA_W-1:0] m_axi_video_tdata,
   output logic              m_axi_video_tvalid,
   output logic              m_axi_video_tuser,
   output logic              m_axi_video_tlast,
   input  logic              m_axi_video_tready,
   input  logic              cfg_wr,
   input  logic [ROW_W-1:0]  cfg_row_start,
   input  logic [ROW_W-1:0]  cfg_row_count,
   input  logic [COL_W-1:0]  cfg_col_start,
   input  logic [COL_W-1:0]  cfg_col_count,
   output logic              cfg_err,
   output logic              err_line,
   output logic              err_sof,
   output logic              frame_done
);

   // Handshake: a beat transfers on s_tvalid && s_tready; in-window beats pass
   // ready/valid straight through, out-of-window beats are sunk with ready=1.
   logic [ROW_W-1:0] sh_rs, sh_rc, ac_rs, ac_rc, w_rs, w_rc, cur_row, row;
   logic [COL_W-1:0] sh_cs, sh_cc, ac_cs, ac_cc, w_cs, w_cc, cur_col, col;
   logic [ROW_W:0]   row_end, cfg_row_end;
   logic [COL_W:0]   col_end, cfg_col_end;
   logic             live, in_win, accept, cfg_ok;
   video_pkg::crop_state_e state;

   crop_pos_counter #(
      .IMG_WIDTH (IMG_WIDTH),
      .IMG_HEIGHT(IMG_HEIGHT),
      .ROW_W     (ROW_W),
      .COL_W     (COL_W)
   ) u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (accept),
      .sof       (s_axi_video_tuser),
      .eol       (s_axi_video_tlast),
      .state     (state),
      .row       (row),
      .col       (col),
      .err_line  (err_line),
      .err_sof   (err_sof),
      .frame_done(frame_done)
   );

   // A SOF beat is judged against the shadow window at position (0,0), since
   // the active window is reloaded from the shadow on that very beat.
   always_comb begin
      w_rs    = s_axi_video_tuser ? sh_rs : ac_rs;
      w_rc    = s_axi_video_tuser ? sh_rc : ac_rc;
      w_cs    = s_axi_video_tuser ? sh_cs : ac_cs;
      w_cc    = s_axi_video_tuser ? sh_cc : ac_cc;
      cur_row = s_axi_video_tuser ? '0 : row;
      cur_col = s_axi_video_tuser ? '0 : col;
      row_end = {1'b0, w_rs} + {1'b0, w_rc};
      col_end = {1'b0, w_cs} + {1'b0, w_cc};
      live    = rst_n && ((state == video_pkg::ACTIVE) || s_axi_video_tuser);
      in_win  = live && (cur_row >= w_rs) && ({1'b0, cur_row} < row_end)
                     && (cur_col >= w_cs) && ({1'b0, cur_col} < col_end);
   end

   assign m_axi_video_tdata  = s_axi_video_tdata;
   assign m_axi_video_tvalid = in_win && s_axi_video_tvalid;
   assign m_axi_video_tuser  = in_win && (cur_row == w_rs) && (cur_col == w_cs);
   assign m_axi_video_tlast  = in_win && ({1'b0, cur_col} == col_end - (COL_W + 1)'(1));
   assign s_axi_video_tready = in_win ? m_axi_video_tready : 1'b1;
   assign accept             = s_axi_video_tvalid && s_axi_video_tready;

   assign cfg_row_end = {1'b0, cfg_row_start} + {1'b0, cfg_row_count};
   assign cfg_col_end = {1'b0, cfg_col_start} + {1'b0, cfg_col_count};
   assign cfg_ok      = (cfg_row_count != '0) && (cfg_col_count != '0)
                     && (cfg_row_end <= (ROW_W + 1)'(IMG_HEIGHT))
                     && (cfg_col_end <= (COL_W + 1)'(IMG_WIDTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_rs   <= ROW_W'(DEF_ROW_START);
         sh_rc   <= ROW_W'(DEF_ROW_COUNT);
         sh_cs   <= COL_W'(DEF_COL_START);
         sh_cc   <= COL_W'(DEF_COL_COUNT);
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_wr && !cfg_ok;
         if (cfg_wr && cfg_ok) begin
            sh_rs <= cfg_row_start;
            sh_rc <= cfg_row_count;
            sh_cs <= cfg_col_start;
            sh_cc <= cfg_col_count;
         end
      end
   end

   // Reads the pre-update shadow, so a coincident cfg_wr lands next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ac_rs <= ROW_W'(DEF_ROW_START);
         ac_rc <= ROW_W'(DEF_ROW_COUNT);
         ac_cs <= COL_W'(DEF_COL_START);
         ac_cc <= COL_W'(DEF_COL_COUNT);
      end else if (accept && s_axi_video_tuser) begin
         ac_rs <= sh_rs;
         ac_rc <= sh_rc;
         ac_cs <= sh_cs;
         ac_cc <= sh_cc;
      end
   end

endmodule
